// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RSP = 2'd1,
    ST_DRAIN    = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer: circular FIFO of {pc, data} entries
// Flush wins over a same-cycle push or pop; push on a full buffer is allowed only alongside a pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     entries [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) entries[wr_ptr] <= push_entry;
  end

  assign head = entries[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch FSM feeding a decode buffer
// Define FETCH_MISALIGN_CHECK_EN to add fetch_fault for misaligned redirect targets.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e     state;
  logic [31:0]      fetch_pc;
  logic [31:0]      pending_pc;
  logic [31:0]      redirect_target;
  logic             hold;
  logic             req_fire;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_target = redirect_pc;
  assign hold            = fetch_fault;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               fetch_fault <= 1'b0;
    else if (redirect_valid) fetch_fault <= (redirect_pc[1:0] != 2'b00);
  end
`else
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign hold            = 1'b0;
`endif

  // Reset gating keeps the request low while reset is held, not just after the first edge.
  assign mem_req_valid = !reset && (state == ST_IDLE) && (count < CNT_W'(DEPTH)) &&
                         !redirect_valid && !hold;
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign push       = (state == ST_WAIT_RSP) && mem_rsp_valid && !redirect_valid;
  assign pop        = instr_valid && instr_ready && !redirect_valid;
  assign push_entry = '{pc: pending_pc, data: mem_rsp_data};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (count)
  );

  assign instr_valid = (count != '0);
  assign instr_data  = instr_valid ? head.data : 32'h0;
  assign instr_pc    = instr_valid ? head.pc   : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      fetch_pc   <= RESET_PC;
      pending_pc <= 32'h0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
      // A request still in flight must have its response swallowed in DRAIN.
      case (state)
        ST_IDLE: state <= req_fire ? ST_DRAIN : ST_IDLE;
        default: state <= mem_rsp_valid ? ST_IDLE : ST_DRAIN;
      endcase
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_fire) begin
            pending_pc <= fetch_pc;
            fetch_pc   <= fetch_pc + PC_INC;
            state      <= ST_WAIT_RSP;
          end
        end
        default: begin
          if (mem_rsp_valid) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit with memory and stream model
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int checks   = 0;
  int failures = 0;

  bit          mem_busy;
  int          mem_cnt;
  int          mem_lat;
  logic [31:0] mem_addr;

  bit          hs, hs_busy, pop_seen, req_valid_snap, ivalid_snap;
  logic [31:0] hs_addr, pop_pc, pop_data;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Called in the low clock phase with inputs set; observes the coming edge, then
  // advances to the next negedge and drives the memory response for the new cycle.
  task automatic cycle();
    #2;
    req_valid_snap = mem_req_valid;
    ivalid_snap    = instr_valid;
    hs             = mem_req_valid && mem_req_ready;
    hs_addr        = mem_req_addr;
    hs_busy        = hs && mem_busy;
    pop_seen       = instr_valid && instr_ready;
    pop_pc         = instr_pc;
    pop_data       = instr_data;
    if (mem_rsp_valid) mem_busy = 1'b0;
    else if (mem_busy && mem_cnt > 0) mem_cnt--;
    if (hs) begin
      mem_busy = 1'b1;
      mem_addr = mem_req_addr;
      mem_cnt  = mem_lat;
    end
    @(negedge clk);
    mem_rsp_valid = mem_busy && (mem_cnt == 0);
    mem_rsp_data  = mem_rsp_valid ? mem_fn(mem_addr) : $urandom;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    mem_busy       = 1'b0;
    mem_cnt        = 0;
    mem_lat        = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    mem_req_ready = 1'b1;
    repeat (3) cycle();
    checks++;
    if (ivalid_snap !== 1'b1) begin failures++; $display("FAIL reset_prefill instr_valid=%b exp=1", ivalid_snap); end
    #3;
    reset = 1'b1;
    mem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); end
    checks++;
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
    checks++;
    if (instr_data !== 32'h0) begin failures++; $display("FAIL reset_instr_data got=%h exp=0", instr_data); end
    checks++;
    if (instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr_pc got=%h exp=0", instr_pc); end
    @(negedge clk);
    mem_busy = 1'b0;
    mem_req_ready = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC) begin
      failures++; $display("FAIL reset_first_req valid=%b addr=%h exp valid=1 addr=%h", mem_req_valid, mem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] reqs[$], pcs[$], datas[$];
    logic [31:0] e;
    do_reset();
    mem_req_ready = 1'b1;
    instr_ready   = 1'b1;
    repeat (14) begin
      cycle();
      if (hs) reqs.push_back(hs_addr);
      if (pop_seen) begin pcs.push_back(pop_pc); datas.push_back(pop_data); end
    end
    checks++;
    if (reqs.size() < 3 || pcs.size() < 3) begin
      failures++; $display("FAIL seq_counts reqs=%0d pops=%0d exp>=3", reqs.size(), pcs.size());
    end
    for (int i = 0; i < 3 && i < reqs.size() && i < pcs.size(); i++) begin
      e = 32'(i) << 2;
      checks++;
      if (reqs[i] !== e) begin failures++; $display("FAIL seq_req[%0d] got=%h exp=%h", i, reqs[i], e); end
      checks++;
      if (pcs[i] !== e || datas[i] !== mem_fn(e)) begin
        failures++; $display("FAIL seq_instr[%0d] pc=%h data=%h exp pc=%h data=%h", i, pcs[i], datas[i], e, mem_fn(e));
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    mem_req_ready = 1'b1;
    n = 0;
    repeat (10) begin cycle(); if (hs) n++; end
    checks++;
    if (n != 2) begin failures++; $display("FAIL bp_fill_reqs got=%0d exp=2", n); end
    checks++;
    if (req_valid_snap !== 1'b0) begin failures++; $display("FAIL bp_full_req_valid got=%b exp=0", req_valid_snap); end
    instr_ready = 1'b1;
    cycle();
    checks++;
    if (!pop_seen || pop_pc !== 32'h0) begin failures++; $display("FAIL bp_pop popped=%b pc=%h exp pc=0", pop_seen, pop_pc); end
    instr_ready = 1'b0;
    n = 0;
    repeat (6) begin
      cycle();
      if (hs) begin
        n++;
        checks++;
        if (hs_addr !== 32'h8) begin failures++; $display("FAIL bp_refill_addr got=%h exp=8", hs_addr); end
      end
    end
    checks++;
    if (n != 1) begin failures++; $display("FAIL bp_refill_reqs got=%0d exp=1", n); end
  endtask

  task automatic test_redirect_wait();
    bit          found, bad_valid;
    int          n;
    logic [31:0] got;
    do_reset();
    mem_req_ready = 1'b1;
    mem_lat       = 2;
    cycle();
    checks++;
    if (!hs || hs_addr !== 32'h0) begin failures++; $display("FAIL rw_first_req hs=%b addr=%h exp addr=0", hs, hs_addr); end
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    found = 1'b0; bad_valid = 1'b0; n = -1; got = 32'h0;
    for (int i = 0; i < 8 && !found; i++) begin
      cycle();
      if (ivalid_snap) bad_valid = 1'b1;
      if (hs) begin found = 1'b1; got = hs_addr; n = i; end
    end
    checks++;
    if (!found || got !== 32'h100) begin failures++; $display("FAIL rw_next_addr found=%b got=%h exp=100", found, got); end
    checks++;
    if (n != 2) begin failures++; $display("FAIL rw_drain_cycles got=%0d exp=2", n); end
    checks++;
    if (bad_valid) begin failures++; $display("FAIL rw_stale_push instr_valid seen=1 exp=0"); end
  endtask

  task automatic test_redirect_rsp();
    do_reset();
    mem_req_ready = 1'b1; cycle();
    mem_req_ready = 1'b0; cycle();
    mem_req_ready = 1'b1; cycle();
    checks++;
    if (ivalid_snap !== 1'b1) begin failures++; $display("FAIL rr_prefill instr_valid=%b exp=1", ivalid_snap); end
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    instr_ready    = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    mem_req_ready  = 1'b1;
    cycle();
    checks++;
    if (ivalid_snap !== 1'b0) begin failures++; $display("FAIL rr_flush instr_valid=%b exp=0", ivalid_snap); end
    checks++;
    if (!hs || hs_addr !== 32'h200) begin failures++; $display("FAIL rr_next_addr hs=%b addr=%h exp=200", hs, hs_addr); end
  endtask

  task automatic test_wrap();
    logic [31:0] reqs[$], pcs[$], datas[$];
    logic [31:0] e;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    instr_ready    = 1'b1;
    repeat (10) begin
      cycle();
      if (hs) reqs.push_back(hs_addr);
      if (pop_seen) begin pcs.push_back(pop_pc); datas.push_back(pop_data); end
    end
    checks++;
    if (reqs.size() < 2 || pcs.size() < 2) begin
      failures++; $display("FAIL wrap_counts reqs=%0d pops=%0d exp>=2", reqs.size(), pcs.size());
    end
    for (int i = 0; i < 2 && i < reqs.size() && i < pcs.size(); i++) begin
      e = (i == 0) ? 32'hFFFF_FFFC : 32'h0;
      checks++;
      if (reqs[i] !== e) begin failures++; $display("FAIL wrap_req[%0d] got=%h exp=%h", i, reqs[i], e); end
      checks++;
      if (pcs[i] !== e || datas[i] !== mem_fn(e)) begin
        failures++; $display("FAIL wrap_instr[%0d] pc=%h data=%h exp pc=%h", i, pcs[i], datas[i], e);
      end
    end
  endtask

  task automatic test_late_rsp();
    do_reset();
    mem_req_ready = 1'b1;
    mem_lat       = 5;
    cycle();
    checks++;
    if (!hs || hs_addr !== 32'h0) begin failures++; $display("FAIL late_req hs=%b addr=%h exp addr=0", hs, hs_addr); end
    mem_req_ready = 1'b0;
    #1;
    reset = 1'b1;
    @(negedge clk);
    reset         = 1'b0;
    mem_busy      = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hBAD0_0BAD;
    cycle();
    cycle();
    checks++;
    if (ivalid_snap !== 1'b0) begin failures++; $display("FAIL late_rsp_ignored instr_valid=%b exp=0", ivalid_snap); end
    mem_req_ready = 1'b1;
    mem_lat       = 0;
    cycle();
    checks++;
    if (!hs || hs_addr !== RESET_PC) begin failures++; $display("FAIL late_next_req hs=%b addr=%h exp=%h", hs, hs_addr, RESET_PC); end
  endtask

  task automatic test_misalign();
`ifdef FETCH_MISALIGN_CHECK_EN
    int n;
    do_reset();
    #1;
    checks++;
    if (fetch_fault !== 1'b0) begin failures++; $display("FAIL fault_reset got=%b exp=0", fetch_fault); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    mem_req_ready  = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    n = 0;
    repeat (5) begin cycle(); if (hs) n++; end
    checks++;
    if (fetch_fault !== 1'b1) begin failures++; $display("FAIL fault_set got=%b exp=1", fetch_fault); end
    checks++;
    if (n != 0) begin failures++; $display("FAIL fault_hold reqs=%0d exp=0", n); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h104;
    cycle();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (fetch_fault !== 1'b0) begin failures++; $display("FAIL fault_clear got=%b exp=0", fetch_fault); end
    cycle();
    checks++;
    if (!hs || hs_addr !== 32'h104) begin failures++; $display("FAIL fault_resume hs=%b addr=%h exp=104", hs, hs_addr); end
`else
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    cycle();
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    cycle();
    checks++;
    if (!hs || hs_addr !== 32'h100) begin failures++; $display("FAIL align_force hs=%b addr=%h exp=100", hs, hs_addr); end
`endif
  endtask

  // Reference: decode must see consecutive word addresses from the last redirect target,
  // requests must follow the same sequence, and never exceed buffer room or one in flight.
  task automatic test_random();
    logic [31:0] exp_req, exp_pc, r;
    int          live, pops;
    bit          consumed;
    do_reset();
    exp_req = RESET_PC;
    exp_pc  = RESET_PC;
    live    = 0;
    pops    = 0;
    for (int c = 0; c < 3000; c++) begin
      mem_req_ready  = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r = r | 32'hFFFF_FFF0;
      redirect_pc = r & 32'hFFFF_FFFC;
      mem_lat     = $urandom_range(0, 3);
      cycle();
      if (redirect_valid) begin
        checks++;
        if (req_valid_snap !== 1'b0) begin failures++; $display("FAIL rnd_req_during_redirect cycle=%0d valid=1 exp=0", c); end
      end
      if (hs) begin
        checks++;
        if (hs_addr !== exp_req) begin failures++; $display("FAIL rnd_req_addr cycle=%0d got=%h exp=%h", c, hs_addr, exp_req); end
        checks++;
        if (hs_busy) begin failures++; $display("FAIL rnd_outstanding cycle=%0d got=2 exp<=1", c); end
        checks++;
        if (live >= DEPTH) begin failures++; $display("FAIL rnd_occupancy cycle=%0d got=%0d exp<%0d", c, live, DEPTH); end
        exp_req = exp_req + 32'd4;
      end
      consumed = pop_seen && !redirect_valid;
      if (consumed) begin
        checks++;
        if (pop_pc !== exp_pc) begin failures++; $display("FAIL rnd_instr_pc cycle=%0d got=%h exp=%h", c, pop_pc, exp_pc); end
        checks++;
        if (pop_data !== mem_fn(exp_pc)) begin failures++; $display("FAIL rnd_instr_data cycle=%0d got=%h exp=%h", c, pop_data, mem_fn(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      live = live + int'(hs) - int'(consumed);
      if (redirect_valid) begin
        exp_req = redirect_pc;
        exp_pc  = redirect_pc;
        live    = 0;
      end
    end
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    mem_req_ready  = 1'b0;
    checks++;
    if (pops < 200) begin failures++; $display("FAIL rnd_progress pops=%0d exp>=200", pops); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rsp();
    test_wrap();
    test_late_rsp();
    test_misalign();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
